// File: rtl/fb_fill_pkg.sv
// Shared framebuffer constants, fill-engine state encoding and lane-mask helper.
// The layout defaults are also used by the video scanout so both sides agree.
package fb_pkg;

  localparam int unsigned DEF_FB_BEGIN = 1024 * 1024 / 4;
  localparam int unsigned DEF_STRIDE   = 1280;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WRITE
  } state_t;

  // Big-endian lanes: byte offset k lives in writedata[31-8k -: 8], enabled by byteenable[3-k].
  function automatic logic [3:0] be_mask(input logic [1:0] lo_off, input logic [1:0] hi_off);
    logic [3:0] m;
    m = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (k >= 32'(lo_off) && k <= 32'(hi_off)) m[2'(3 - k)] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fb_fill_if.sv
// Command handshake and Avalon-style framebuffer write port of the fill engine.
interface fb_fill_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_x;
  logic [11:0] cmd_y;
  logic [11:0] cmd_w;
  logic [11:0] cmd_h;
  logic [7:0]  cmd_color;
  logic        busy;
  logic        done;
  logic [29:0] fb_address;
  logic        fb_write;
  logic [31:0] fb_writedata;
  logic [3:0]  fb_byteenable;
  logic        fb_waitrequest;

  modport master (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, fb_waitrequest,
    output cmd_ready, busy, done, fb_address, fb_write, fb_writedata, fb_byteenable
  );

  modport slave (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, fb_waitrequest,
    input  cmd_ready, busy, done, fb_address, fb_write, fb_writedata, fb_byteenable
  );

endinterface

// File: rtl/fb_fill.sv
// Rectangle fill engine: walks the rectangle row by row and issues masked 32-bit
// framebuffer writes, one byte per RGB332 pixel.
module fb_fill
  import fb_pkg::*;
#(
  parameter int unsigned FB_BEGIN = DEF_FB_BEGIN,
  parameter int unsigned STRIDE   = DEF_STRIDE
) (
  input  logic      memory_clock,
  input  logic      reset,
  fb_fill_if.master bus
);

  state_t      state;
  state_t      state_next;

  logic [29:0] row_addr;
  logic [11:0] rows_left;
  logic [11:0] width;
  logic [7:0]  color;
  logic [29:0] end_addr;
  logic [29:0] word;
  logic [3:0]  be;

  logic [29:0] start_addr;
  logic [29:0] row_end;
  logic [29:0] row_word;
  logic [29:0] end_word;
  logic [29:0] next_word;
  logic [3:0]  first_be;
  logic [3:0]  next_be;
  logic        fill_over;
  logic        last_word;
  logic        accept;

  // The only multiply: once per command; rows then advance by STRIDE additions.
  assign start_addr = 30'(FB_BEGIN) + 30'(32'(bus.cmd_y) * STRIDE) + 30'(bus.cmd_x);

  assign row_end   = row_addr + 30'(width) - 30'd1;
  assign row_word  = {row_addr[29:2], 2'b00};
  assign first_be  = (row_word == {row_end[29:2], 2'b00})
                   ? be_mask(row_addr[1:0], row_end[1:0])
                   : be_mask(row_addr[1:0], 2'd3);
  assign fill_over = (rows_left == '0) || (width == '0);

  assign end_word  = {end_addr[29:2], 2'b00};
  assign last_word = (word == end_word);
  assign next_word = word + 30'd4;
  assign next_be   = (next_word == end_word) ? be_mask(2'd0, end_addr[1:0]) : '1;
  assign accept    = !bus.fb_waitrequest;

  always_ff @(posedge memory_clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.cmd_ready = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.fb_write  = 1'b0;
    unique case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_next = SETUP;
      end
      SETUP: begin
        bus.busy = 1'b1;
        if (fill_over) begin
          bus.done   = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        bus.busy     = 1'b1;
        bus.fb_write = 1'b1;
        if (accept && last_word) state_next = SETUP;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge memory_clock) begin
    if (reset) begin
      row_addr  <= '0;
      rows_left <= '0;
      width     <= '0;
      color     <= '0;
      end_addr  <= '0;
      word      <= '0;
      be        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            row_addr  <= start_addr;
            rows_left <= bus.cmd_h;
            width     <= bus.cmd_w;
            color     <= bus.cmd_color;
          end
        end
        SETUP: begin
          if (!fill_over) begin
            end_addr <= row_end;
            word     <= row_word;
            be       <= first_be;
          end
        end
        WRITE: begin
          if (accept) begin
            if (last_word) begin
              rows_left <= rows_left - 12'd1;
              row_addr  <= row_addr + 30'(STRIDE);
            end else begin
              word <= next_word;
              be   <= next_be;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fb_address    = word;
  assign bus.fb_byteenable = be;
  assign bus.fb_writedata  = {4{color}};

endmodule

// File: tb/tb_fb_fill.sv
// Scoreboard bench for fb_fill: expected writes/done pulses are queued with their
// cycle offset from command acceptance and checked by an independent monitor.
module tb_fb_fill;

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    int          rel;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_base = 0;
  int   errors = 0;
  int   checks = 0;
  bit   stall_en = 1'b0;
  int   stall_lo = 0;
  int   stall_hi = 0;

  wr_t  exp_q[$];
  int   done_q[$];

  fb_fill_if bus ();

  fb_fill #(
    .FB_BEGIN(32'h4_0000),
    .STRIDE  (1280)
  ) dut (
    .memory_clock(clk),
    .reset       (reset),
    .bus         (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    bus.fb_waitrequest = stall_en && (cyc - n_base >= stall_lo) && (cyc - n_base <= stall_hi);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!reset || bus.fb_write) begin
      if (bus.fb_write === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {2'b00, bus.fb_address}, 32'hFFFF_FFFF);
        end else begin
          check("wr_addr", {2'b00, bus.fb_address}, {2'b00, exp_q[0].addr});
          check("wr_be", {28'd0, bus.fb_byteenable}, {28'd0, exp_q[0].be});
          check("wr_data", bus.fb_writedata, exp_q[0].data);
          if (bus.fb_waitrequest === 1'b0) begin
            check("wr_cycle", cyc - n_base, exp_q[0].rel);
            void'(exp_q.pop_front());
          end
        end
      end
      if (bus.done === 1'b1) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", cyc - n_base, 32'hFFFF_FFFF);
        end else begin
          check("done_cycle", cyc - n_base, done_q.pop_front());
          check("busy_at_done", {31'd0, bus.busy}, 32'd1);
        end
      end
    end
  end

  task automatic push_wr(input logic [29:0] a, input logic [3:0] b, input logic [7:0] c,
                         input int rel);
    wr_t e;
    e.addr = a;
    e.be   = b;
    e.data = {4{c}};
    e.rel  = rel;
    exp_q.push_back(e);
  endtask

  task automatic issue(input int x, input int y, input int w, input int h, input logic [7:0] c);
    @(posedge clk);
    #1;
    bus.cmd_x     = 12'(x);
    bus.cmd_y     = 12'(y);
    bus.cmd_w     = 12'(w);
    bus.cmd_h     = 12'(h);
    bus.cmd_color = c;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    check("cmd_ready_at_accept", {31'd0, bus.cmd_ready}, 32'd1);
    n_base = cyc;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_x     = '1;
    bus.cmd_y     = '1;
    bus.cmd_w     = '1;
    bus.cmd_h     = '1;
    bus.cmd_color = 8'h33;
    @(negedge clk);
    check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && done_q.size() == 0 && bus.cmd_ready === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < 200), 32'd1);
    exp_q.delete();
    done_q.delete();
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_x     = '0;
    bus.cmd_y     = '0;
    bus.cmd_w     = '0;
    bus.cmd_h     = '0;
    bus.cmd_color = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_fb_write", {31'd0, bus.fb_write}, 32'd0);
    check("rst_fb_address", {2'b00, bus.fb_address}, 32'd0);
    check("rst_fb_writedata", bus.fb_writedata, 32'd0);
    check("rst_fb_byteenable", {28'd0, bus.fb_byteenable}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // Single pixel at offset 1
    push_wr(30'h4_0000, 4'b0100, 8'hE0, 2);
    done_q.push_back(3);
    issue(1, 0, 1, 1, 8'hE0);
    wait_idle();

    // 8x2 full words, one idle cycle between rows
    push_wr(30'h4_0000, 4'b1111, 8'h5A, 2);
    push_wr(30'h4_0004, 4'b1111, 8'h5A, 3);
    push_wr(30'h4_0500, 4'b1111, 8'h5A, 5);
    push_wr(30'h4_0504, 4'b1111, 8'h5A, 6);
    done_q.push_back(7);
    issue(0, 0, 8, 2, 8'h5A);
    wait_idle();

    // Partial first and last words
    push_wr(30'h4_0500, 4'b0001, 8'h1C, 2);
    push_wr(30'h4_0504, 4'b1111, 8'h1C, 3);
    push_wr(30'h4_0508, 4'b1000, 8'h1C, 4);
    done_q.push_back(5);
    issue(3, 1, 6, 1, 8'h1C);
    wait_idle();

    // 8x2 with the second word stalled three cycles
    stall_en = 1'b1;
    stall_lo = 3;
    stall_hi = 5;
    push_wr(30'h4_0000, 4'b1111, 8'hA5, 2);
    push_wr(30'h4_0004, 4'b1111, 8'hA5, 6);
    push_wr(30'h4_0500, 4'b1111, 8'hA5, 8);
    push_wr(30'h4_0504, 4'b1111, 8'hA5, 9);
    done_q.push_back(10);
    issue(0, 0, 8, 2, 8'hA5);
    wait_idle();
    stall_en = 1'b0;

    // Zero width: no writes, done right after accept
    done_q.push_back(1);
    issue(0, 0, 0, 5, 8'hFF);
    @(negedge clk);
    check("zero_w_ready_n2", {31'd0, bus.cmd_ready}, 32'd1);
    check("zero_w_done_seen", 32'(done_q.size()), 32'd0);
    wait_idle();

    // Reset while the second word of the first row is on the bus
    push_wr(30'h4_0000, 4'b1111, 8'h77, 2);
    push_wr(30'h4_0004, 4'b1111, 8'h77, 3);
    issue(0, 0, 8, 2, 8'h77);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_fb_write", {31'd0, bus.fb_write}, 32'd0);
    check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_mid_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rst_mid_pending", 32'(exp_q.size()), 32'd0);
    repeat (10) @(negedge clk);

    // Fresh command after the abandoned one
    push_wr(30'h4_0500, 4'b0001, 8'hC3, 2);
    push_wr(30'h4_0504, 4'b1111, 8'hC3, 3);
    push_wr(30'h4_0508, 4'b1000, 8'hC3, 4);
    done_q.push_back(5);
    issue(3, 1, 6, 1, 8'hC3);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
